// File: rtl/sdram_chip_responder.sv
// Device-side model of one SDR SDRAM chip: decodes the command bus, tracks open rows per bank,
// stores write bursts in a small array and returns read bursts after the programmed CAS latency.
`timescale 1ns/1ps
module sdram_chip_responder #(
  parameter int ROW_WIDTH       = 12,
  parameter int COL_WIDTH       = 9,
  parameter int BANK_ADDR_WIDTH = 2,
  parameter int MEM_ADDR_WIDTH  = 12
) (
  input  logic                       clk,
  input  logic                       reset_port,
  input  logic                       ck_en_port,
  input  logic                       cs_n_port,
  input  logic                       ras_n_port,
  input  logic                       cas_n_port,
  input  logic                       wr_en_port,
  input  logic [ROW_WIDTH-1:0]       addr_port,
  input  logic [BANK_ADDR_WIDTH-1:0] bank_addr_port,
  input  logic                       ldqm_port,
  input  logic                       udqm_port,
  inout  wire  [15:0]                data_port,
  output logic                       protocol_error_port,
  output logic [15:0]                refresh_count_port,
  output logic [1:0]                 state_o,
  output logic [1:0]                 dq_oe_o
);

  localparam int NUM_BANKS = 1 << BANK_ADDR_WIDTH;
  localparam int FULL_W    = BANK_ADDR_WIDTH + ROW_WIDTH + COL_WIDTH;
  localparam int MEM_WORDS = 1 << MEM_ADDR_WIDTH;

  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;
  localparam logic [3:0] CMD_BST = 4'b0110;

  typedef enum logic [1:0] {
    ST_UNINIT   = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_RD_BURST = 2'd3
  } state_e;

  // Handshake: there is none; every command is qualified only by CKE=1 and CS_n=0 on a rising edge.

  state_e                       state_q, state_d;
  logic [NUM_BANKS-1:0]         bank_open_q, bank_open_d;
  logic [ROW_WIDTH-1:0]         open_row_q [NUM_BANKS];
  logic [ROW_WIDTH-1:0]         open_row_d [NUM_BANKS];
  logic                         cl3_q, cl3_d;
  logic [1:0]                   bl_log2_q, bl_log2_d;
  logic                         err_q, err_d;
  logic [15:0]                  ref_cnt_q, ref_cnt_d;

  logic [BANK_ADDR_WIDTH-1:0]   bb_q, bb_d;
  logic [ROW_WIDTH-1:0]         brow_q, brow_d;
  logic [COL_WIDTH-1:0]         bcol_q, bcol_d;
  logic [2:0]                   bk_q, bk_d;
  logic                         bap_q, bap_d;

  logic                         s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [MEM_ADDR_WIDTH-1:0]    s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
  logic [15:0]                  dq_out_q, dq_out_d;
  logic [1:0]                   dq_oe_q, dq_oe_d;
  logic [1:0]                   dqm_q, dqm_d;

  logic [15:0]                  mem [MEM_WORDS];

  logic [3:0]                   cmd;
  logic                         in_burst, uninit, new_wr;
  logic [2:0]                   bl_m1;
  logic                         iss_valid, iss_wr, iss_ap;
  logic [BANK_ADDR_WIDTH-1:0]   iss_bank;
  logic [ROW_WIDTH-1:0]         iss_row;
  logic [COL_WIDTH-1:0]         iss_col, col_k;
  logic [2:0]                   iss_k, low_sum;
  logic [FULL_W-1:0]            full_addr;
  logic [MEM_ADDR_WIDTH-1:0]    iss_addr, rd_src_addr;
  logic                         rd_src_vld;
  logic [15:0]                  rd_word, dq_in;

  assign cmd      = {cs_n_port, ras_n_port, cas_n_port, wr_en_port};
  assign in_burst = (state_q == ST_WR_BURST) || (state_q == ST_RD_BURST);
  assign uninit   = (state_q == ST_UNINIT);
  assign dq_in    = data_port;

  always_comb begin
    case (bl_log2_q)
      2'd0:    bl_m1 = 3'd0;
      2'd1:    bl_m1 = 3'd1;
      2'd2:    bl_m1 = 3'd3;
      default: bl_m1 = 3'd7;
    endcase
  end

  // Command decode, bank bookkeeping and burst sequencing.
  always_comb begin
    state_d     = state_q;
    bank_open_d = bank_open_q;
    open_row_d  = open_row_q;
    cl3_d       = cl3_q;
    bl_log2_d   = bl_log2_q;
    err_d       = err_q;
    ref_cnt_d   = ref_cnt_q;
    bb_d        = bb_q;
    brow_d      = brow_q;
    bcol_d      = bcol_q;
    bk_d        = bk_q;
    bap_d       = bap_q;
    new_wr      = 1'b0;
    iss_valid   = 1'b0;
    iss_wr      = (state_q == ST_WR_BURST);
    iss_bank    = bb_q;
    iss_row     = brow_q;
    iss_col     = bcol_q;
    iss_k       = bk_q;
    iss_ap      = bap_q;

    case (cmd)
      CMD_LMR: begin
        if (in_burst || (|bank_open_q)) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          case (addr_port[6:4])
            3'd2:    cl3_d = 1'b0;
            3'd3:    cl3_d = 1'b1;
            default: begin cl3_d = 1'b0; err_d = 1'b1; end
          endcase
          if (addr_port[2]) begin
            bl_log2_d = 2'd0;
            err_d     = 1'b1;
          end else begin
            bl_log2_d = addr_port[1:0];
          end
        end
      end
      CMD_ACT: begin
        if (uninit || bank_open_q[bank_addr_port]) begin
          err_d = 1'b1;
        end else begin
          bank_open_d[bank_addr_port] = 1'b1;
          open_row_d[bank_addr_port]  = addr_port;
        end
      end
      CMD_RD, CMD_WR: begin
        if (uninit || !bank_open_q[bank_addr_port]) begin
          err_d = 1'b1;
        end else begin
          iss_valid = 1'b1;
          iss_wr    = (cmd == CMD_WR);
          new_wr    = (cmd == CMD_WR);
          iss_bank  = bank_addr_port;
          iss_row   = open_row_q[bank_addr_port];
          iss_col   = addr_port[COL_WIDTH-1:0];
          iss_k     = 3'd0;
          iss_ap    = addr_port[10];
        end
      end
      CMD_PRE: begin
        if (addr_port[10]) bank_open_d = '0;
        else               bank_open_d[bank_addr_port] = 1'b0;
        if (in_burst && (addr_port[10] || (bank_addr_port == bb_q))) state_d = ST_IDLE;
      end
      CMD_REF: begin
        ref_cnt_d = ref_cnt_q + 16'd1;
        if (|bank_open_q) err_d = 1'b1;
      end
      CMD_BST: begin
        if (in_burst) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // An uninterrupted burst issues its next word this edge.
    if (in_burst && !iss_valid && (state_d == state_q)) iss_valid = 1'b1;

    if (iss_valid) begin
      if (iss_k == bl_m1) begin
        state_d = ST_IDLE;
        if (iss_ap) bank_open_d[iss_bank] = 1'b0;
      end else begin
        state_d = iss_wr ? ST_WR_BURST : ST_RD_BURST;
        bb_d    = iss_bank;
        brow_d  = iss_row;
        bcol_d  = iss_col;
        bk_d    = iss_k + 3'd1;
        bap_d   = iss_ap;
      end
    end
  end

  // Column of word k wraps inside the BL-aligned block.
  always_comb begin
    low_sum     = iss_col[2:0] + iss_k;
    col_k       = iss_col;
    col_k[2:0]  = (iss_col[2:0] & ~bl_m1) | (low_sum & bl_m1);
    full_addr   = {iss_bank, iss_row, col_k};
    iss_addr    = full_addr[MEM_ADDR_WIDTH-1:0];
  end

  assign rd_src_vld  = cl3_q ? s2_vld_q  : s1_vld_q;
  assign rd_src_addr = cl3_q ? s2_addr_q : s1_addr_q;
  assign rd_word     = mem[rd_src_addr];

  // Read pipeline: s1 holds the word issued this edge, s2 adds the extra stage for CL3.
  always_comb begin
    s1_vld_d  = iss_valid && !iss_wr;
    s1_addr_d = iss_addr;
    s2_vld_d  = s1_vld_q && cl3_q && !new_wr;
    s2_addr_d = s1_addr_q;
    dq_out_d  = rd_src_vld ? rd_word : dq_out_q;
    dq_oe_d   = (rd_src_vld && !new_wr) ? ~dqm_q : 2'b00;
    dqm_d     = {udqm_port, ldqm_port};
  end

  always_ff @(posedge clk or posedge reset_port) begin
    if (reset_port) begin
      state_q     <= ST_UNINIT;
      bank_open_q <= '0;
      open_row_q  <= '{default: '0};
      cl3_q       <= 1'b0;
      bl_log2_q   <= 2'd0;
      err_q       <= 1'b0;
      ref_cnt_q   <= 16'd0;
      bb_q        <= '0;
      brow_q      <= '0;
      bcol_q      <= '0;
      bk_q        <= 3'd0;
      bap_q       <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_addr_q   <= '0;
      s2_vld_q    <= 1'b0;
      s2_addr_q   <= '0;
      dq_out_q    <= 16'd0;
      dq_oe_q     <= 2'b00;
      dqm_q       <= 2'b00;
    end else if (ck_en_port) begin
      state_q     <= state_d;
      bank_open_q <= bank_open_d;
      open_row_q  <= open_row_d;
      cl3_q       <= cl3_d;
      bl_log2_q   <= bl_log2_d;
      err_q       <= err_d;
      ref_cnt_q   <= ref_cnt_d;
      bb_q        <= bb_d;
      brow_q      <= brow_d;
      bcol_q      <= bcol_d;
      bk_q        <= bk_d;
      bap_q       <= bap_d;
      s1_vld_q    <= s1_vld_d;
      s1_addr_q   <= s1_addr_d;
      s2_vld_q    <= s2_vld_d;
      s2_addr_q   <= s2_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      dqm_q       <= dqm_d;
    end
  end

  // Storage is deliberately not reset; write DQM applies to the same edge as the data.
  always_ff @(posedge clk) begin
    if (ck_en_port && iss_valid && iss_wr) begin
      if (!ldqm_port) mem[iss_addr][7:0]  <= dq_in[7:0];
      if (!udqm_port) mem[iss_addr][15:8] <= dq_in[15:8];
    end
  end

  assign data_port[7:0]  = dq_oe_q[0] ? dq_out_q[7:0]  : 8'hzz;
  assign data_port[15:8] = dq_oe_q[1] ? dq_out_q[15:8] : 8'hzz;

  assign protocol_error_port = err_q;
  assign refresh_count_port  = ref_cnt_q;
  assign state_o             = state_q;
  assign dq_oe_o             = dq_oe_q;

endmodule

// File: tb/tb_sdram_chip_responder.sv
// Directed bench for sdram_chip_responder: a table of per-edge commands with expected bus state,
// followed by hand-written sequences for violations, refresh, CKE hold and reset mid-read.
`timescale 1ns/1ps
module tb_sdram_chip_responder;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;

  localparam logic [1:0] S_UNINIT = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_WR     = 2'd2;
  localparam logic [1:0] S_RD     = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cke, cs_n, ras_n, cas_n, we_n, ldqm, udqm;
  logic [11:0] addr;
  logic [1:0]  ba;
  logic [15:0] tb_dq;
  logic        tb_dq_en;
  wire  [15:0] dq;
  logic        err;
  logic [15:0] rcnt;
  logic [1:0]  st, oe;

  assign dq = tb_dq_en ? tb_dq : 16'hzzzz;

  sdram_chip_responder dut (
    .clk                 (clk),
    .reset_port          (rst),
    .ck_en_port          (cke),
    .cs_n_port           (cs_n),
    .ras_n_port          (ras_n),
    .cas_n_port          (cas_n),
    .wr_en_port          (we_n),
    .addr_port           (addr),
    .bank_addr_port      (ba),
    .ldqm_port           (ldqm),
    .udqm_port           (udqm),
    .data_port           (dq),
    .protocol_error_port (err),
    .refresh_count_port  (rcnt),
    .state_o             (st),
    .dq_oe_o             (oe)
  );

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [11:0] a;
    logic [1:0]  dqm;   // {udqm, ldqm}
    logic        drv;
    logic [15:0] wd;
    logic [1:0]  st;
    logic [1:0]  oe;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a,
                              input logic [1:0] m, input logic d, input logic [15:0] w,
                              input logic [1:0] s, input logic [1:0] o, input logic [15:0] r);
    vec_t v;
    v.cmd = c; v.ba = b; v.a = a; v.dqm = m; v.drv = d; v.wd = w;
    v.st = s; v.oe = o; v.rd = r;
    return v;
  endfunction

  // scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic chk_read(input string nm, input logic [1:0] exp_oe, input logic [15:0] exp_d);
    logic [15:0] lane;
    chk({nm, " oe"}, 32'(oe), 32'(exp_oe));
    if (exp_oe != 2'b00) begin
      lane = {{8{exp_oe[1]}}, {8{exp_oe[0]}}};
      chk({nm, " data"}, 32'(dq & lane), 32'(exp_d & lane));
    end
  endtask

  // driver: apply one command for one rising edge, return 2 time units after it
  task automatic tick(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a,
                      input logic [1:0] m, input logic d, input logic [15:0] w);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba = b; addr = a; {udqm, ldqm} = m; tb_dq_en = d; tb_dq = w;
    @(posedge clk);
    #2;
    tb_dq_en = 1'b0;
    {cs_n, ras_n, cas_n, we_n} = NOP;
    {udqm, ldqm} = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    cke = 1'b1; {cs_n, ras_n, cas_n, we_n} = NOP; addr = '0; ba = '0;
    ldqm = 1'b0; udqm = 1'b0; tb_dq = '0; tb_dq_en = 1'b0;
    do_reset();

    chk("reset state", 32'(st), 32'(S_UNINIT));
    chk("reset oe", 32'(oe), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset refresh", 32'(rcnt), 32'd0);

    // CL2/BL1 write-then-read
    tbl.push_back(mk(LMR, 2'd0, 12'h020, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(ACT, 2'd1, 12'h005, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(WR,  2'd1, 12'h010, 2'b00, 1, 16'hA55A, S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(RD,  2'd1, 12'h010, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b11, 16'hA55A));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    // CL3/BL4 burst with wrap inside the aligned block
    tbl.push_back(mk(PRE, 2'd0, 12'h400, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(LMR, 2'd0, 12'h032, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(ACT, 2'd1, 12'h005, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(WR,  2'd1, 12'h002, 2'b00, 1, 16'h1111, S_WR,   2'b00, 16'h0));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 1, 16'h2222, S_WR,   2'b00, 16'h0));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 1, 16'h3333, S_WR,   2'b00, 16'h0));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 1, 16'h4444, S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(RD,  2'd1, 12'h002, 2'b00, 0, 16'h0,    S_RD,   2'b00, 16'h0));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_RD,   2'b00, 16'h0));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_RD,   2'b11, 16'h1111));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b11, 16'h2222));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b11, 16'h3333));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b11, 16'h4444));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(RD,  2'd1, 12'h000, 2'b00, 0, 16'h0,    S_RD,   2'b00, 16'h0));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_RD,   2'b00, 16'h0));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_RD,   2'b11, 16'h3333));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b11, 16'h4444));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b11, 16'h1111));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b11, 16'h2222));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    // byte masks on write and read, then auto-precharge
    tbl.push_back(mk(PRE, 2'd0, 12'h400, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(LMR, 2'd0, 12'h020, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(ACT, 2'd2, 12'h0A3, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(WR,  2'd2, 12'h055, 2'b00, 1, 16'h1234, S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(WR,  2'd2, 12'h055, 2'b10, 1, 16'hBEEF, S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(RD,  2'd2, 12'h055, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b11, 16'h12EF));
    tbl.push_back(mk(RD,  2'd2, 12'h055, 2'b01, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b10, 16'h1200));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(RD,  2'd2, 12'h055, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b01, 0, 16'h0,    S_IDLE, 2'b11, 16'h12EF));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(RD,  2'd2, 12'h455, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b11, 16'h12EF));
    tbl.push_back(mk(ACT, 2'd2, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));
    tbl.push_back(mk(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0,    S_IDLE, 2'b00, 16'h0));

    foreach (tbl[i]) begin
      tick(tbl[i].cmd, tbl[i].ba, tbl[i].a, tbl[i].dqm, tbl[i].drv, tbl[i].wd);
      chk($sformatf("row%0d state", i), 32'(st), 32'(tbl[i].st));
      chk($sformatf("row%0d err", i), 32'(err), 32'd0);
      chk_read($sformatf("row%0d", i), tbl[i].oe, tbl[i].rd);
    end

    // READ before LOAD MODE
    do_reset();
    tick(RD, 2'd0, 12'h000, 2'b00, 0, 16'h0);
    chk("uninit read err", 32'(err), 32'd1);
    chk("uninit read state", 32'(st), 32'(S_UNINIT));
    tick(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0);
    chk("uninit read oe1", 32'(oe), 32'd0);
    tick(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0);
    chk("uninit read oe2", 32'(oe), 32'd0);

    // double ACTIVE on one bank
    do_reset();
    tick(LMR, 2'd0, 12'h020, 2'b00, 0, 16'h0);
    tick(ACT, 2'd0, 12'h001, 2'b00, 0, 16'h0);
    chk("first act err", 32'(err), 32'd0);
    tick(ACT, 2'd0, 12'h001, 2'b00, 0, 16'h0);
    chk("double act err", 32'(err), 32'd1);

    // illegal CL falls back to CL2
    do_reset();
    tick(LMR, 2'd0, 12'h010, 2'b00, 0, 16'h0);
    chk("bad cl err", 32'(err), 32'd1);
    chk("bad cl state", 32'(st), 32'(S_IDLE));
    tick(ACT, 2'd0, 12'h000, 2'b00, 0, 16'h0);
    tick(WR,  2'd0, 12'h007, 2'b00, 1, 16'h5A5A);
    tick(RD,  2'd0, 12'h007, 2'b00, 0, 16'h0);
    tick(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0);
    chk_read("bad cl read", 2'b11, 16'h5A5A);

    // refresh counting and CKE hold
    do_reset();
    tick(LMR, 2'd0, 12'h020, 2'b00, 0, 16'h0);
    repeat (3) tick(REF, 2'd0, 12'h000, 2'b00, 0, 16'h0);
    chk("refresh count", 32'(rcnt), 32'd3);
    chk("refresh err", 32'(err), 32'd0);
    cke = 1'b0;
    tick(REF, 2'd0, 12'h000, 2'b00, 0, 16'h0);
    cke = 1'b1;
    chk("cke hold count", 32'(rcnt), 32'd3);

    // reset in the middle of a BL8 read
    tick(LMR, 2'd0, 12'h023, 2'b00, 0, 16'h0);
    tick(ACT, 2'd0, 12'h000, 2'b00, 0, 16'h0);
    tick(RD,  2'd0, 12'h000, 2'b00, 0, 16'h0);
    tick(NOP, 2'd0, 12'h000, 2'b00, 0, 16'h0);
    chk("bl8 driving oe", 32'(oe), 32'd3);
    chk("bl8 state", 32'(st), 32'(S_RD));
    #1 rst = 1'b1;
    #1;
    chk("async reset oe", 32'(oe), 32'd0);
    chk("async reset state", 32'(st), 32'(S_UNINIT));
    chk("async reset count", 32'(rcnt), 32'd0);
    chk("async reset err", 32'(err), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdram_chip_responder.md
# sdram_chip_responder

Synthesizable single-chip SDR SDRAM responder: the device end of the command bus driven by `sdram_controller`. It decodes CS/RAS/CAS/WE commands, tracks per-bank open rows, and stores write data in a small internal array. It returns read data after the programmed CAS latency and flags protocol violations. It is instantiated twice (chip0/chip1) in controller benches and FPGA loopback builds, sharing the address, bank and command lines.

## Interface
- `ROW_WIDTH`, 12, row address bits (also width of `addr_port`)
- `COL_WIDTH`, 9, column address bits
- `BANK_ADDR_WIDTH`, 2, bank bits (4 banks)
- `MEM_ADDR_WIDTH`, 12, log2 of storage words; index = low MEM_ADDR_WIDTH bits of {bank,row,col}; aliasing allowed
- `clk` in 1: single clock, all inputs sampled on rising edge
- `reset_port` in 1: asynchronous, active-high reset
- `ck_en_port` in 1: CKE; when 0, the command is ignored and all state holds
- `cs_n_port`, `ras_n_port`, `cas_n_port`, `wr_en_port` in 1 each: command
- `addr_port` in ROW_WIDTH: row / column / A10 / mode
- `bank_addr_port` in BANK_ADDR_WIDTH
- `ldqm_port`, `udqm_port` in 1: byte masks
- `data_port` inout 16: DQ; hi-Z unless driving read data
- `protocol_error_port` out 1: sticky violation flag
- `refresh_count_port` out 16: AUTO REFRESH counter, wraps at 0xFFFF→0

## Operation
- Command {cs_n,ras_n,cas_n,we_n}: 1xxx or 0111 = NOP, 0011 = ACTIVE, 0101 = READ, 0100 = WRITE, 0010 = PRECHARGE (A10=1: all banks), 0001 = AUTO REFRESH, 0000 = LOAD MODE, 0110 = BURST TERMINATE.
- States:
  - UNINIT: entered on reset. Only LOAD MODE moves to IDLE. Any ACTIVE, READ or WRITE here sets the error flag and is ignored.
  - IDLE
  - WR_BURST
  - RD_BURST
- LOAD MODE: CL = A[6:4] (2 or 3; other values → error, CL=2); BL = 1/2/4/8 from A[2:0] = 0/1/2/3 (other values → error, BL=1). Sequential bursts only. LOAD MODE while any bank is open, or during a burst → error, ignored.
- ACTIVE: opens row in bank. Bank already open → error, ignored.
- READ/WRITE: column = A[COL_WIDTH-1:0]; A10=1 auto-precharges the bank at burst end. Target bank not open → error, ignored.
- Burst column k = {col[high], (col[low log2 BL bits] + k) mod BL}, i.e. wraps inside the BL-aligned block.
- A new READ or WRITE, BURST TERMINATE, or PRECHARGE of the bursting bank ends the current burst immediately. The new command then starts its own burst.
- WRITE: word k is taken from `data_port` at edge N+k. Byte lanes are written only where the mask is 0 (ldqm→[7:0], udqm→[15:8]); write DQM latency is 0.
- READ: word k is driven so it is valid at edge N+CL+k. Read DQM latency is 2: a mask sampled at edge M tri-states that byte lane for the word valid at edge M+2.
- WRITE issued while read words are still in the CL pipeline flushes the pipeline; the bus goes hi-Z from the next edge.
- AUTO REFRESH with any bank open → error; count still increments.
- Error flag is cleared only by reset. Memory contents are not reset.

## Timing
- Reset values:
  - state UNINIT
  - all banks closed
  - CL=2, BL=1
  - `data_port` hi-Z
  - `protocol_error_port`=0
  - `refresh_count_port`=0
- Read output register loads at edge N+CL-1+k. Data is stable from that edge until after edge N+CL+k; `data_port` returns to hi-Z after the last word.
- Bank open and close take effect at the command edge; a READ one cycle after ACTIVE is accepted (tRCD is not checked).
- Auto-precharge closes the bank at the edge of the last burst word.
- Reset mid-burst: bus goes hi-Z asynchronously; pipeline cleared.

## Test plan
- Write then read:
  - LOAD MODE A=0x020 (CL2, BL1), ACTIVE bank1 row 0x05, WRITE col 0x010 with data 0xA55A, READ col 0x010.
  - Required: 0xA55A valid on `data_port` at READ edge +2; hi-Z otherwise; error stays 0.
- Burst wrap:
  - LOAD MODE CL3 BL4; write 0x1111/0x2222/0x3333/0x4444 at col 0x002.
  - Read col 0x002 → 0x1111, 0x2222, 0x3333, 0x4444 at edges +3..+6.
  - Read col 0x000 → 0x3333, 0x4444, 0x1111, 0x2222.
- Masks:
  - WRITE 0xBEEF with udqm=1 over existing 0x1234 → stored value 0x12EF.
  - Read with ldqm=1 two cycles before the data edge → low byte hi-Z, high byte 0x12.
- Violations:
  - READ before LOAD MODE → error=1, no drive.
  - After reset, ACTIVE the same bank twice → error=1.
- Refresh: three AUTO REFRESH commands with all banks closed → count=3, error=0. Assert CKE=0 during one refresh → count unchanged.
- Reset mid-read: assert `reset_port` while a BL8 read is active → `data_port` goes hi-Z immediately, outputs return to reset values, state UNINIT.
